// File: rtl/skolem_ugt_udiv_checker_if.sv
// Operand/witness bus between the checker and the combinational Skolem block it drives.
interface skolem_ugt_udiv_checker_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] sk_s;
  logic [W-1:0] sk_t;
  logic [W-1:0] sk_x;

  modport master (output sk_s, output sk_t, input sk_x);
  modport slave  (input sk_s, input sk_t, output sk_x);
endinterface

// File: rtl/skolem_ugt_udiv_checker.sv
// Exhaustive checker for the Skolem witness of (x bvudiv s) bvugt t: walks every (s,t),
// captures the witness and re-evaluates IC and formula with one shared serial divider.
module skolem_ugt_udiv_checker #(
  parameter int unsigned W      = 4,
  parameter int unsigned SK_LAT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  skolem_ugt_udiv_checker_if.master sk,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [2*W:0]              ic_cnt,
  output logic [2*W:0]              fail_cnt,
  output logic                      fail_seen,
  output logic [W-1:0]              ff_s,
  output logic [W-1:0]              ff_t,
  output logic [W-1:0]              ff_x
);

  localparam int unsigned VW       = 2 * W;
  localparam int unsigned CW       = 2 * W + 1;
  localparam int unsigned STEP_MAX = (SK_LAT + 1 > W) ? SK_LAT + 1 : W;
  localparam int unsigned SW       = $clog2(STEP_MAX + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_DIV_IC = 3'd2;
  localparam logic [2:0] ST_DIV_X  = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [W-1:0]  xr_q, xr_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  qic_q, qic_d;
  logic [CW-1:0] ic_cnt_q, ic_cnt_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;
  logic          fail_seen_q, fail_seen_d;
  logic [W-1:0]  ff_s_q, ff_s_d;
  logic [W-1:0]  ff_t_q, ff_t_d;
  logic [W-1:0]  ff_x_q, ff_x_d;
  logic [W-1:0]  sk_s_q, sk_s_d;
  logic [W-1:0]  sk_t_q, sk_t_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [W-1:0]  cur_s, cur_t;
  logic [W+1:0]  trial, diff;
  logic          qbit;
  logic [W:0]    rem_nx;
  logic [W-1:0]  quo_nx;
  logic          ic, ok;

  assign cur_s = vec_q[VW-1:W];
  assign cur_t = vec_q[W-1:0];

  // One restoring step: quo_q doubles as the dividend shifter, quotient bits enter at the LSB.
  // A zero divisor always subtracts, giving the all-ones quotient bvudiv defines.
  always_comb begin
    trial  = {rem_q, quo_q[W-1]};
    diff   = trial - (W+2)'(cur_s);
    qbit   = (trial >= (W+2)'(cur_s));
    rem_nx = (W+1)'(qbit ? diff : trial);
    quo_nx = {quo_q[W-2:0], qbit};
  end

  assign ic = (cur_t < qic_q);
  assign ok = (quo_q > cur_t);

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    vec_d       = vec_q;
    xr_d        = xr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    qic_d       = qic_q;
    ic_cnt_d    = ic_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_seen_d = fail_seen_q;
    ff_s_d      = ff_s_q;
    ff_t_d      = ff_t_q;
    ff_x_d      = ff_x_q;
    sk_s_d      = sk_s_q;
    sk_t_d      = sk_t_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ic_cnt_d    = '0;
          fail_cnt_d  = '0;
          fail_seen_d = 1'b0;
          ff_s_d      = '0;
          ff_t_d      = '0;
          ff_x_d      = '0;
          vec_d       = '0;
          sk_s_d      = '0;
          sk_t_d      = '0;
          step_d      = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (step_q == SW'(SK_LAT)) begin
          xr_d    = sk.sk_x;
          step_d  = '0;
          rem_d   = '0;
          quo_d   = '1;
          state_d = ST_DIV_IC;
        end else begin
          step_d = step_q + SW'(1);
        end
      end

      ST_DIV_IC: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        step_d = step_q + SW'(1);
        if (step_q == SW'(W - 1)) begin
          qic_d   = quo_nx;
          rem_d   = '0;
          quo_d   = xr_q;
          step_d  = '0;
          state_d = ST_DIV_X;
        end
      end

      ST_DIV_X: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        step_d = step_q + SW'(1);
        if (step_q == SW'(W - 1)) begin
          step_d  = '0;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // IC-false vectors are vacuous and leave both counters alone.
        if (ic) begin
          ic_cnt_d = ic_cnt_q + CW'(1);
        end
        if (ic && !ok) begin
          fail_cnt_d = fail_cnt_q + CW'(1);
          if (!fail_seen_q) begin
            fail_seen_d = 1'b1;
            ff_s_d      = cur_s;
            ff_t_d      = cur_t;
            ff_x_d      = xr_q;
          end
        end
        vec_d = vec_q + VW'(1);
        if (vec_q == '1) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
          state_d = ST_DONE;
        end else begin
          sk_s_d  = vec_d[VW-1:W];
          sk_t_d  = vec_d[W-1:0];
          state_d = ST_DRIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      vec_q       <= '0;
      xr_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      qic_q       <= '0;
      ic_cnt_q    <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      ff_s_q      <= '0;
      ff_t_q      <= '0;
      ff_x_q      <= '0;
      sk_s_q      <= '0;
      sk_t_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      vec_q       <= vec_d;
      xr_q        <= xr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      qic_q       <= qic_d;
      ic_cnt_q    <= ic_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_seen_q <= fail_seen_d;
      ff_s_q      <= ff_s_d;
      ff_t_q      <= ff_t_d;
      ff_x_q      <= ff_x_d;
      sk_s_q      <= sk_s_d;
      sk_t_q      <= sk_t_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign sk.sk_s   = sk_s_q;
  assign sk.sk_t   = sk_t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign ic_cnt    = ic_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_seen = fail_seen_q;
  assign ff_s      = ff_s_q;
  assign ff_t      = ff_t_q;
  assign ff_x      = ff_x_q;

endmodule
